// File: rtl/text_overlay_pkg.sv
// Shared definitions for the text overlay: animation mode encodings and a
// width helper used to size counters and indices.
package text_overlay_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        MODE_STATIC       = 2'b00,
        MODE_BLINK        = 2'b01,
        MODE_SCROLL       = 2'b10,
        MODE_SCROLL_BLINK = 2'b11
    } mode_e;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/overlay_anim_timer.sv
// Per-frame animation timer: advances the horizontal scroll position and the
// blink visibility on each frame_start, according to the latched mode.
module overlay_anim_timer
    import text_overlay_pkg::*;
#(
    parameter int GLYPH_W    = 22,
    parameter int SCROLL_DIV = 4,
    parameter int BLINK_DIV  = 30,
    parameter int POS_W      = clog2_min1(GLYPH_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  mode_e            mode_q,
    output logic [POS_W-1:0] scroll_pos,
    output logic             blink_vis
);

    localparam int SC_W = clog2_min1(SCROLL_DIV);
    localparam int BL_W = clog2_min1(BLINK_DIV);

    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCROLL_DIV - 1);
    localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK_DIV - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(GLYPH_W - 1);

    logic [SC_W-1:0] scroll_cnt;
    logic [BL_W-1:0] blink_cnt;

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scroll_cnt <= '0;
            scroll_pos <= '0;
        end else if (frame_start) begin
            if (mode_q[1]) begin
                if (scroll_cnt == SC_LAST) begin
                    scroll_cnt <= '0;
                    scroll_pos <= (scroll_pos == POS_LAST) ? '0 : scroll_pos + 1'b1;
                end else begin
                    scroll_cnt <= scroll_cnt + 1'b1;
                end
            end else begin
                scroll_cnt <= '0;
                scroll_pos <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else if (frame_start) begin
            if (mode_q[0]) begin
                if (blink_cnt == BL_LAST) begin
                    blink_cnt <= '0;
                    blink_vis <= ~blink_vis;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end else begin
                blink_cnt <= '0;
                blink_vis <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/text_overlay_anim.sv
// Bitmap text overlay: maps pixel (x, y) onto a writable 1-bpp glyph bitmap on
// a coarse cell grid, with scroll/blink animation and a registered output.
module text_overlay_anim
    import text_overlay_pkg::*;
#(
    parameter int GLYPH_W    = 22,
    parameter int GLYPH_H    = 9,
    parameter int SCALE_LOG2 = 3,
    parameter int ORIGIN_X   = 30,
    parameter int ORIGIN_Y   = 25,
    parameter int SCROLL_DIV = 4,
    parameter int BLINK_DIV  = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               frame_start,
    input  logic [1:0]         mode,
    input  logic               wr_en,
    input  logic [3:0]         wr_row,
    input  logic [GLYPH_W-1:0] wr_data,
    output logic               overlay_active
);

    localparam int CELL_W = COORD_W - SCALE_LOG2;
    localparam int POS_W  = clog2_min1(GLYPH_W);
    localparam int ROW_W  = clog2_min1(GLYPH_H);

    localparam logic [CELL_W-1:0] ORG_X   = CELL_W'(ORIGIN_X);
    localparam logic [CELL_W-1:0] ORG_Y   = CELL_W'(ORIGIN_Y);
    localparam logic [CELL_W:0]   GW_EXT  = (CELL_W + 1)'(GLYPH_W);
    localparam logic [CELL_W:0]   GH_EXT  = (CELL_W + 1)'(GLYPH_H);
    localparam logic [4:0]        GH_WR   = 5'(GLYPH_H);

    logic [GLYPH_W-1:0] bitmap [GLYPH_H];
    mode_e              mode_q;
    logic [POS_W-1:0]   scroll_pos;
    logic               blink_vis;

    logic [CELL_W-1:0]  off_x;
    logic [CELL_W-1:0]  off_y;
    logic [CELL_W:0]    col_sum;
    logic               in_range;
    logic [ROW_W-1:0]   row_sel;
    logic [POS_W-1:0]   col_sel;
    logic               lit;
    logic               unused_low_bits;

    // Sub-cell pixel bits do not affect which cell is addressed.
    assign unused_low_bits = ^{x[SCALE_LOG2-1:0], y[SCALE_LOG2-1:0]};

    // Negative offsets wrap to large unsigned values and fail the range test.
    assign off_x    = x[COORD_W-1:SCALE_LOG2] - ORG_X;
    assign off_y    = y[COORD_W-1:SCALE_LOG2] - ORG_Y;
    assign in_range = ({1'b0, off_x} < GW_EXT) && ({1'b0, off_y} < GH_EXT);
    assign col_sum  = {1'b0, off_x} + (CELL_W + 1)'(scroll_pos);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        row_sel = '0;
        col_sel = '0;
        if (in_range) begin
            row_sel = off_y[ROW_W-1:0];
            col_sel = POS_W'((col_sum >= GW_EXT) ? col_sum - GW_EXT : col_sum);
        end
    end

    assign lit = bitmap[row_sel][col_sel];

    // NOTE: the bitmap is reset because the overlay must read blank after reset;
    // this costs reset fan-out on every storage flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < GLYPH_H; r++) bitmap[r] <= '0;
        end else if (wr_en && ({1'b0, wr_row} < GH_WR)) begin
            bitmap[wr_row] <= wr_data;
        end
    end

    // The timer sees the pre-edge mode_q, so a new mode takes effect one frame later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_STATIC;
        end else if (frame_start) begin
            mode_q <= mode_e'(mode);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overlay_active <= 1'b0;
        end else begin
            overlay_active <= in_range & lit & blink_vis;
        end
    end

    overlay_anim_timer #(
        .GLYPH_W    (GLYPH_W),
        .SCROLL_DIV (SCROLL_DIV),
        .BLINK_DIV  (BLINK_DIV),
        .POS_W      (POS_W)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .mode_q      (mode_q),
        .scroll_pos  (scroll_pos),
        .blink_vis   (blink_vis)
    );

endmodule
